// File: rtl/cam_reg_scheduler.sv
// Purpose: serialises OV5640 register writes (boot ROM walk + runtime writes) onto the i2c_master streams.
// Latency: ROM entry -> cmd_valid after ROM_LATENCY+2 clocks; runtime capture -> cmd_valid next clock.
// Backpressure: cmd/data valids hold their payload until ready; the next write waits for i2c_busy to fall.
module cam_reg_scheduler #(
  parameter logic [6:0] DEV_ADDR      = 7'h3C,
  parameter int         ROM_DEPTH     = 256,
  parameter int         ROM_LATENCY   = 2,
  parameter int         CYCLES_PER_MS = 100000,
  localparam int        AW            = $clog2(ROM_DEPTH)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          init_valid,
  output logic          init_ready,
  output logic          init_done,
  output logic [AW-1:0] bram_addr,
  input  logic [23:0]   bram_dout,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [15:0]   wr_addr,
  input  logic [7:0]    wr_data,
  output logic [6:0]    cmd_address,
  output logic          cmd_start,
  output logic          cmd_write_multiple,
  output logic          cmd_stop,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [7:0]    data_tdata,
  output logic          data_tvalid,
  input  logic          data_tready,
  output logic          data_tlast,
  input  logic          i2c_busy,
  output logic          busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ROM_RD, S_DECODE, S_DELAY, S_CMD,
    S_BYTE0, S_BYTE1, S_BYTE2, S_WAIT_BUS, S_NEXT, S_DONE
  } state_t;

  localparam logic [31:0]   CPM  = 32'(CYCLES_PER_MS);
  localparam logic [AW-1:0] LAST = AW'(ROM_DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] addr;
  logic [23:0]   word;        // {reg_addr, data} of the write in flight
  logic [7:0]    lat_cnt;
  logic [31:0]   dly_cnt;
  logic [1:0]    grd_cnt;
  logic          busy_seen;
  logic          src_rom;     // current transaction belongs to the ROM walk
  logic          init_pend;   // init request parked behind a runtime write
  logic          done_q;

  logic rom_active, init_take, wr_take, lat_done, dly_done, bus_done, last_entry;

  assign rom_active = src_rom && (state != S_IDLE);
  assign init_take  = (state == S_IDLE) && (init_valid || init_pend);
  assign wr_take    = wr_valid && wr_ready;
  assign lat_done   = (lat_cnt == 8'(ROM_LATENCY));
  assign dly_done   = (dly_cnt >= ({24'd0, word[7:0]} * CPM));
  // A master that never raises busy would otherwise stall us forever.
  assign bus_done   = !i2c_busy && (busy_seen || (grd_cnt == 2'd3));
  assign last_entry = (addr == LAST);

  assign init_ready  = (state == S_IDLE) && !init_pend;
  // Init has priority over a simultaneous runtime write.
  assign wr_ready    = (state == S_IDLE) && !init_pend && !init_valid && !rst_in;
  assign init_done   = done_q;
  assign bram_addr   = addr;
  assign busy        = (state != S_IDLE);
  assign cmd_address = DEV_ADDR;

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (init_valid || init_pend) state_nxt = S_ROM_RD;
                  else if (wr_take)            state_nxt = S_CMD;
      S_ROM_RD:   if (lat_done) state_nxt = S_DECODE;
      S_DECODE:   if (word == 24'hFFFFFF)          state_nxt = S_DONE;
                  else if (word[23:8] == 16'hFFFE) state_nxt = S_DELAY;
                  else                             state_nxt = S_CMD;
      S_DELAY:    if (dly_done)    state_nxt = S_NEXT;
      S_CMD:      if (cmd_ready)   state_nxt = S_BYTE0;
      S_BYTE0:    if (data_tready) state_nxt = S_BYTE1;
      S_BYTE1:    if (data_tready) state_nxt = S_BYTE2;
      S_BYTE2:    if (data_tready) state_nxt = S_WAIT_BUS;
      S_WAIT_BUS: if (bus_done)    state_nxt = src_rom ? S_NEXT : S_IDLE;
      S_NEXT:     state_nxt = last_entry ? S_DONE : S_ROM_RD;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; payload comes from the captured word.
  always_comb begin
    cmd_valid   = 1'b0;
    data_tvalid = 1'b0;
    data_tdata  = 8'd0;
    data_tlast  = 1'b0;
    case (state)
      S_CMD:   cmd_valid = 1'b1;
      S_BYTE0: begin data_tvalid = 1'b1; data_tdata = word[23:16]; end
      S_BYTE1: begin data_tvalid = 1'b1; data_tdata = word[15:8];  end
      S_BYTE2: begin data_tvalid = 1'b1; data_tdata = word[7:0]; data_tlast = 1'b1; end
      default: ;
    endcase
  end

  assign cmd_start          = cmd_valid;
  assign cmd_write_multiple = cmd_valid;
  assign cmd_stop           = cmd_valid;

  // Datapath: ROM pointer, captured word, wait counters, request bookkeeping.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      addr      <= '0;
      word      <= '0;
      lat_cnt   <= '0;
      dly_cnt   <= '0;
      grd_cnt   <= '0;
      busy_seen <= 1'b0;
      src_rom   <= 1'b0;
      init_pend <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      lat_cnt <= (state == S_ROM_RD) ? lat_cnt + 8'd1 : 8'd0;

      if (state == S_DELAY) begin
        if (dly_cnt != '1) dly_cnt <= dly_cnt + 32'd1;
      end else begin
        dly_cnt <= '0;
      end

      if (state == S_WAIT_BUS) begin
        if (grd_cnt != 2'd3) grd_cnt <= grd_cnt + 2'd1;
        if (i2c_busy)        busy_seen <= 1'b1;
      end else begin
        grd_cnt   <= '0;
        busy_seen <= 1'b0;
      end

      if ((state == S_ROM_RD) && lat_done) word <= bram_dout;
      if (wr_take) begin
        word    <= {wr_addr, wr_data};
        src_rom <= 1'b0;
      end
      if (init_take) begin
        addr      <= '0;
        src_rom   <= 1'b1;
        init_pend <= 1'b0;
      end
      if ((state == S_NEXT) && !last_entry) addr <= addr + AW'(1);

      // Requests during a ROM walk are dropped; during a runtime write they wait.
      if (init_valid && !rom_active && (state != S_IDLE)) init_pend <= 1'b1;
      if (init_valid && !rom_active) done_q <= 1'b0;
      if (state == S_DONE)           done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_reg_scheduler.sv
module tb_cam_reg_scheduler;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;
  localparam int CPM   = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_valid = 1'b0, init_ready, init_done;
  logic [3:0]  bram_addr;
  logic [23:0] bram_dout;
  logic        wr_valid = 1'b0, wr_ready;
  logic [15:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [6:0]  cmd_address;
  logic        cmd_start, cmd_write_multiple, cmd_stop, cmd_valid, cmd_ready;
  logic [7:0]  data_tdata;
  logic        data_tvalid, data_tready, data_tlast, i2c_busy, busy;

  cam_reg_scheduler #(.DEV_ADDR(7'h3C), .ROM_DEPTH(DEPTH), .ROM_LATENCY(LAT), .CYCLES_PER_MS(CPM)) dut (
    .clk_in(clk), .rst_in(rst), .init_valid(init_valid), .init_ready(init_ready), .init_done(init_done),
    .bram_addr(bram_addr), .bram_dout(bram_dout), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .cmd_address(cmd_address), .cmd_start(cmd_start),
    .cmd_write_multiple(cmd_write_multiple), .cmd_stop(cmd_stop), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .data_tdata(data_tdata), .data_tvalid(data_tvalid),
    .data_tready(data_tready), .data_tlast(data_tlast), .i2c_busy(i2c_busy), .busy(busy));

  initial forever #5 clk = ~clk;

  int          nchk = 0, nfail = 0;
  int          cyc = 0;
  logic [23:0] rom [DEPTH];
  logic [8:0]  got_q[$], exp_q[$];   // {tlast, byte}
  int          cmd_t[$], end_t[$];
  int          stall_b1 = 0, stall_seen = 0, stall_bad = 0;
  logic [7:0]  stall_exp = '0;
  bit          no_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin @(posedge clk); cyc++; end

  // ROM with two clocks from address change to data.
  initial begin
    logic [3:0]  a;
    logic [23:0] p1;
    p1 = '1;
    bram_dout = '0;
    forever begin
      @(posedge clk);
      a = bram_addr;
      #1;
      bram_dout = p1;
      p1 = rom[a];
    end
  end

  // I2C master model: random readies, byte capture, busy pulse after each transaction.
  initial begin
    bit         pc, pd;
    logic [7:0] prev_d;
    int         bidx, busy_left;
    bit         busy_pend;
    cmd_ready = 1'b0; data_tready = 1'b0; i2c_busy = 1'b0;
    pc = 0; pd = 0; prev_d = '0; bidx = 0; busy_left = 0; busy_pend = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cmd_ready = 1'b0; data_tready = 1'b0; i2c_busy = 1'b0;
        pc = 0; pd = 0; bidx = 0; busy_left = 0; busy_pend = 0;
        continue;
      end
      if (pc) chk("cmd_valid_hold", 32'(cmd_valid), 32'd1);
      if (pd) begin
        chk("tvalid_hold", 32'(data_tvalid), 32'd1);
        chk("tdata_hold", 32'(data_tdata), 32'(prev_d));
      end
      if (i2c_busy) begin
        if (busy_left > 0) busy_left--;
        else i2c_busy = 1'b0;
      end
      if (busy_pend) begin busy_pend = 0; i2c_busy = 1'b1; end
      cmd_ready = cmd_valid && ($urandom_range(0, 2) != 0);
      if (data_tvalid && bidx == 1 && stall_b1 > 0) begin
        data_tready = 1'b0;
        stall_b1--;
        stall_seen++;
        if (data_tdata !== stall_exp) stall_bad++;
      end else begin
        data_tready = data_tvalid && ($urandom_range(0, 3) != 0);
      end
      if (cmd_valid && cmd_ready) begin
        cmd_t.push_back(cyc);
        chk("cmd_address", 32'(cmd_address), 32'h3C);
        chk("cmd_flags", 32'({cmd_start, cmd_write_multiple, cmd_stop}), 32'h7);
      end
      if (data_tvalid && data_tready) begin
        got_q.push_back({data_tlast, data_tdata});
        if (data_tlast) begin
          bidx = 0;
          end_t.push_back(cyc);
          if (!no_busy) begin busy_pend = 1; busy_left = $urandom_range(0, 4); end
        end else begin
          bidx++;
        end
      end
      pc = cmd_valid && !cmd_ready;
      pd = data_tvalid && !data_tready;
      prev_d = data_tdata;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, busy=%0d", busy);
    $fatal(1, "watchdog");
  end

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = 24'hFFFFFF;
  endtask

  function automatic void push_w(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({1'b0, a[15:8]});
    exp_q.push_back({1'b0, a[7:0]});
    exp_q.push_back({1'b1, d});
  endfunction

  // Expected bus traffic of one ROM walk: stop at terminator or end of ROM, skip delays.
  function automatic void push_rom();
    for (int i = 0; i < DEPTH; i++) begin
      if (rom[i] == 24'hFFFFFF) break;
      if (rom[i][23:8] != 16'hFFFE) push_w(rom[i][23:8], rom[i][7:0]);
    end
  endfunction

  task automatic pulse_init(input string tag);
    @(negedge clk); init_valid = 1'b1;
    @(negedge clk); #1;
    chk({tag, "_init_ready"}, 32'(init_ready), 32'd0);
    chk({tag, "_init_done_clr"}, 32'(init_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    init_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n, quiet;
    n = 0; quiet = 0;
    while (quiet < 3 && n < 5000) begin
      @(negedge clk); n++;
      quiet = busy ? 0 : quiet + 1;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_wr(input logic [15:0] a, input logic [7:0] d, input bit need_done, input string tag);
    int n;
    n = 0;
    @(negedge clk); wr_addr = a; wr_data = d; wr_valid = 1'b1; #1;
    while (!wr_ready && n < 3000) begin @(negedge clk); #1; n++; end
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    if (need_done) chk({tag, "_wr_after_done"}, 32'(init_done), 32'd1);
    @(negedge clk); #1;
    chk({tag, "_wr_ready_1cyc"}, 32'(wr_ready), 32'd0);
    wr_valid = 1'b0;
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete(); exp_q.delete(); cmd_t.delete(); end_t.delete();
  endtask

  initial begin
    int          n, gap;
    logic [15:0] ra;
    logic [7:0]  rd;
    clear_rom();

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_init_ready", 32'(init_ready), 32'd1);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_valids", 32'({cmd_valid, data_tvalid, data_tlast, cmd_start}), 32'd0);
    chk("rst_bram_addr", 32'(bram_addr), 32'd0);
    chk("rst_tdata", 32'(data_tdata), 32'd0);
    #2 rst = 1'b0;

    // Two ROM writes then terminator
    rom[0] = 24'h300882; rom[1] = 24'h310311;
    push_rom();
    pulse_init("t1");
    wait_idle("t1");
    chk("t1_init_done", 32'(init_done), 32'd1);
    chk("t1_init_ready", 32'(init_ready), 32'd1);
    cmp_stream("t1_bytes");

    // Delay entry between writes; master never raises busy (guard path)
    no_busy = 1'b1;
    clear_rom(); rom[0] = 24'h300882; rom[1] = 24'hFFFE03; rom[2] = 24'h310311;
    push_rom();
    pulse_init("t2");
    wait_idle("t2");
    gap = (cmd_t.size() > 1 && end_t.size() > 0) ? cmd_t[1] - end_t[0] : 0;
    chk("t2_delay_gap_ge30", 32'(gap >= 30), 32'd1);
    chk("t2_init_done", 32'(init_done), 32'd1);
    cmp_stream("t2_bytes");
    no_busy = 1'b0;

    // Runtime write while idle
    push_w(16'h3500, 8'h5A);
    do_wr(16'h3500, 8'h5A, 1'b0, "t3");
    wait_idle("t3");
    chk("t3_init_ready", 32'(init_ready), 32'd1);
    cmp_stream("t3_bytes");

    // Runtime write held off by a random ROM walk containing a 0 ms delay
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
    rom[2] = 24'hFFFE00;
    ra = 16'($urandom_range(0, 16'hFFFD)); rd = 8'($urandom);
    push_rom(); push_w(ra, rd);
    pulse_init("t4");
    do_wr(ra, rd, 1'b1, "t4");
    wait_idle("t4");
    cmp_stream("t4_bytes");

    // data_tready withheld 7 cycles on the second byte
    stall_b1 = 7; stall_seen = 0; stall_bad = 0; stall_exp = 8'hAB;
    push_w(16'h12AB, 8'hCD);
    do_wr(16'h12AB, 8'hCD, 1'b0, "t5");
    wait_idle("t5");
    chk("t5_stall_cycles", 32'(stall_seen), 32'd7);
    chk("t5_stall_tdata", 32'(stall_bad), 32'd0);
    cmp_stream("t5_bytes");

    // init during a runtime write is parked and runs afterwards
    ra = 16'($urandom_range(0, 16'hFFFD)); rd = 8'($urandom);
    push_w(ra, rd); push_rom();
    do_wr(ra, rd, 1'b0, "t6");
    pulse_init("t6");
    wait_idle("t6");
    chk("t6_init_done", 32'(init_done), 32'd1);
    cmp_stream("t6_bytes");

    // Reset in the middle of the second byte, then a clean restart
    clear_rom(); rom[0] = 24'h300882; rom[1] = 24'h310311;
    stall_b1 = 1000; stall_exp = 8'h08;
    pulse_init("t7a");
    n = 0;
    while (!(data_tvalid && got_q.size() == 1) && n < 500) begin @(negedge clk); n++; end
    chk("t7_at_byte1", 32'(data_tvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_tvalid", 32'(data_tvalid), 32'd0);
    chk("t7_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_init_ready", 32'(init_ready), 32'd1);
    chk("t7_rst_bram_addr", 32'(bram_addr), 32'd0);
    repeat (2) @(negedge clk);
    stall_b1 = 0;
    got_q.delete(); cmd_t.delete(); end_t.delete();
    #2 rst = 1'b0;
    push_rom();
    pulse_init("t7b");
    wait_idle("t7");
    chk("t7_init_done", 32'(init_done), 32'd1);
    cmp_stream("t7_bytes");

    // Full ROM with no terminator; a second init mid-walk is ignored
    no_busy = bit'($urandom_range(0, 1));
    for (int i = 0; i < DEPTH; i++) rom[i] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
    push_rom();
    pulse_init("t8a");
    repeat (20) @(negedge clk);
    pulse_init("t8b");
    wait_idle("t8");
    chk("t8_init_done", 32'(init_done), 32'd1);
    cmp_stream("t8_bytes");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
